// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall gating, trap/redirect override and a
// circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              INSTR_BYTES = 4,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pc_write,
  input  logic                           trap_valid,
  input  logic [XLEN-1:0]                trap_vector,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_target,
  input  logic                           call_valid,
  input  logic [XLEN-1:0]                call_target,
  input  logic                           ret_valid,
  output logic [XLEN-1:0]                pc_out,
  output logic [XLEN-1:0]                pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [XLEN-1:0]  ras_top;
  logic             ras_we;

  assign pc_out    = pc_reg;
  assign pc_plus   = pc_reg + XLEN'(INSTR_BYTES);
  assign ras_count = count_reg;
  assign ras_empty = (count_reg == '0);
  assign ras_top   = ras_mem[ptr_reg];

  // ptr_reg always addresses the newest entry; writes go to ptr_next.
  always_comb begin
    pc_next    = pc_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    ras_we     = 1'b0;
    if (trap_valid) begin
      pc_next    = trap_vector;
      count_next = '0;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (pc_write) begin
      if (call_valid && ret_valid && count_reg != '0) begin
        // Pop then push collapses to overwriting the top in place.
        pc_next = call_target;
        ras_we  = 1'b1;
      end else if (call_valid) begin
        pc_next  = call_target;
        ptr_next = ptr_reg + PTR_W'(1);
        ras_we   = 1'b1;
        if (count_reg != CNT_FULL)
          count_next = count_reg + CNT_W'(1);
      end else if (ret_valid && count_reg != '0) begin
        pc_next    = ras_top;
        ptr_next   = ptr_reg - PTR_W'(1);
        count_next = count_reg - CNT_W'(1);
      end else begin
        pc_next = pc_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VEC;
      count_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we && !rst)
      ras_mem[ptr_next] <= pc_plus;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter: the next-generation PC register, with stall gating, execute-stage redirect, trap vectoring and a small return-address stack (RAS) for call/return prediction. It sits at the head of the IF stage and drives the instruction-memory address. Hazard, branch and exception logic feed it directly.

## Interface
- XLEN, 32: PC / address width.
- RESET_VEC, 0: value loaded into pc_out on reset (XLEN bits).
- INSTR_BYTES, 4: sequential increment.
- RAS_DEPTH, 4: RAS entries, power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pc_write  in  1  1 = PC may advance; 0 = stall (hold), except for trap or redirect.
- trap_valid  in  1  exception or interrupt taken.
- trap_vector  in  XLEN  trap handler address.
- redirect_valid  in  1  branch or jump resolved in EX mispredicted.
- redirect_target  in  XLEN  corrected PC.
- call_valid  in  1  predecoded call at pc_out.
- call_target  in  XLEN  call destination.
- ret_valid  in  1  predecoded return at pc_out.
- pc_out  out  XLEN  current fetch PC (registered).
- pc_plus  out  XLEN  pc_out + INSTR_BYTES (combinational).
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_empty  out  1  ras_count == 0.

## Operation
- Next-PC priority, evaluated each cycle: rst > trap_valid > redirect_valid > (pc_write == 0: hold) > call_valid > ret_valid > sequential.
- Reset: pc_out = RESET_VEC, ras_count = 0, ras_empty = 1. RAS storage contents are don't-care.
- Trap: pc_out <= trap_vector, RAS flushed (count 0). This takes effect regardless of pc_write.
- Redirect: pc_out <= redirect_target, regardless of pc_write. RAS is untouched.
- Stall (pc_write = 0, no trap or redirect): pc_out and the RAS hold. call_valid and ret_valid are ignored.
- Call (advancing): pc_out <= call_target, and pc_plus is pushed.
  - If the RAS is full, the oldest entry is overwritten (circular) and ras_count saturates at RAS_DEPTH.
- Return (advancing, ras_count > 0): pc_out <= top entry, which is popped and ras_count is decremented.
- Return with the RAS empty: pc_out <= pc_plus, the RAS is unchanged, no error. EX corrects this through a redirect.
- call_valid and ret_valid both high: pop, then push pc_plus (top replaced), pc_out <= call_target, and ras_count is unchanged.
- Sequential: pc_out <= pc_plus.
- Arithmetic: all additions are modulo 2^XLEN. PC 0xFFFFFFFC + 4 wraps to 0. Targets are used unmodified, with no alignment masking.
- RAS implementation: storage array plus top pointer of width $clog2(RAS_DEPTH); the pointer wraps modulo RAS_DEPTH.

## Timing
- Every input is sampled at posedge clk; the new pc_out is visible one cycle later (latency 1).
- pc_plus follows pc_out combinationally, in the same cycle.
- The RAS top is read combinationally from the current state. A pop and a new pc_out take effect on the same edge.
- rst asserted mid-stream overrides every other input on that edge. The first post-reset fetch is at RESET_VEC, in the cycle after rst is released.
- A stall of N cycles holds pc_out for exactly N cycles.
- Trap or redirect during a stall takes effect on the next edge.

## Test plan
- Reset and sequential: with RESET_VEC = 0x100, release rst and hold pc_write = 1 for 3 cycles. Expect pc_out = 0x100, 0x104, 0x108, 0x10C.
- Stall vs redirect: hold pc_write = 0 for 2 cycles, then assert redirect_valid with 0x2000 while still stalled. Expect pc_out held for 2 cycles, then 0x2000 on the next edge.
- Priority: in one cycle assert trap_valid (0x80), redirect_valid (0x4000) and call_valid. Expect pc_out = 0x80 and ras_count = 0.
- Call/return: at pc 0x10, call 0x500; at 0x500, call 0x900; then ret, ret. Expect pc_out = 0x500, 0x900, 0x504, 0x14, with ras_count 1, 2, 1, 0.
- RAS overflow: with RAS_DEPTH = 4, issue 5 nested calls, then 5 returns. Expect ras_count saturates at 4 and the first 4 returns pop the newest 4 addresses. Expect the 5th return falls through to pc_plus with ras_empty = 1.
- Wrap and simultaneous: advance from pc 0xFFFFFFFC and expect 0x0. Then assert call_valid and ret_valid together with 1 entry in the RAS. Expect pc_out = call_target, ras_count = 1, and the top equal to the old pc_plus.
